multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the operand and result width; legal values are 8 to 64.
REQ-002 The block SHALL have parameter SHW, default 5, which sets the shift-amount width and SHALL equal log2(WIDTH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operation request is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a request this cycle.
REQ-007 The block SHALL have port src1, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port src2, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port func, input, 3 bits: the opcode.
REQ-010 The block SHALL have port shift, input, SHW bits: the shift amount for SLL, SRL and SRA.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result, carry and overflow are valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port result, output, WIDTH bits: the registered result.
REQ-014 The block SHALL have port carry, output, 1 bit: carry-out for ADD; for SUB, 1 means no borrow.
REQ-015 The block SHALL have port overflow, output, 1 bit: signed overflow for ADD and SUB.
REQ-016 The block SHALL have port busy, output, 1 bit: a multiply is in progress.

Function
REQ-017 func encoding SHALL be: 000 SLL (src1<<shift), 001 ADD, 010 SUB (src1+~src2+1), 011 OR, 100 AND, 101 SRL, 110 SRA, 111 MUL (low WIDTH bits of src1*src2, unsigned).
REQ-018 ADD and SUB SHALL use a carry-lookahead adder built from 4-bit CLA groups with ripple between groups; WIDTH not divisible by 4 SHALL pad the top group.
REQ-019 The FSM SHALL have states IDLE, MUL and DONE.
REQ-020 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; operands and func SHALL be captured on that edge.
REQ-021 in_ready SHALL be 1 in IDLE, SHALL be 1 in DONE when out_ready=1, and SHALL be 0 in MUL.
REQ-022 A non-MUL op SHALL go to DONE on the accept edge; out_valid=1 SHALL follow in the next cycle, giving a latency of 1 cycle.
REQ-023 MUL SHALL go to MUL with an iteration counter of 0 and SHALL shift-and-add one multiplier bit per cycle.
REQ-024 After WIDTH iterations, MUL SHALL go to DONE; out_valid SHALL rise WIDTH+1 cycles after the accept edge.
REQ-025 busy SHALL be 1 exactly while in MUL.
REQ-026 In DONE, result, carry and overflow SHALL hold stable until out_valid && out_ready.
REQ-027 On the handshake edge, DONE SHALL go to IDLE, or SHALL accept a new request in the same edge if in_valid=1 (back-to-back, no bubble).
REQ-028 carry and overflow SHALL be 0 for every op other than ADD and SUB.
REQ-029 overflow SHALL equal (carry into MSB) XOR (carry out of MSB).
REQ-030 A shift amount of 0 SHALL return src1 unchanged; SRA SHALL replicate src1[WIDTH-1].
REQ-031 in_valid while in MUL SHALL be ignored; the upstream holds the request.
REQ-032 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-033 Asserting rst SHALL, immediately and independent of clk, force the state to IDLE.
REQ-034 During rst the outputs SHALL be result=0, carry=0, overflow=0, out_valid=0 and busy=0.
REQ-035 During rst, in_ready SHALL be 0; it SHALL be 1 in the first cycle after deassertion.
REQ-036 Reset asserted mid-MUL SHALL abort the multiply with no result produced; the counter and partial product SHALL be cleared.

Verification (WIDTH=32)
REQ-037 ADD with 0x7FFFFFFF + 0x00000001 -> result 0x80000000, carry 0, overflow 1, out_valid one cycle after accept.
REQ-038 SUB with 0x00000005 - 0x00000007 -> result 0xFFFFFFFE, carry 0, overflow 0; SUB 7-5 -> result 2, carry 1.
REQ-039 SRA of 0x80000000 by 4 -> result 0xF8000000; SLL of 0x00000001 by 31 -> result 0x80000000; SRL of 0x80000000 by 0 -> result 0x80000000.
REQ-040 MUL with 0x00010001 * 0x00010001 -> result 0x00020001, out_valid at accept+33, busy high for 32 cycles, in_ready low throughout.
REQ-041 Hold out_ready=0 for 5 cycles after an OR result -> result stable and out_valid high throughout; raise out_ready with in_valid=1 -> new request accepted on the same edge.
REQ-042 Assert rst at cycle 10 of a MUL -> out_valid stays 0, busy drops to 0 asynchronously, and the next ADD completes correctly.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle shift/logic/add ops plus a bit-serial shift-and-add multiply.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [2:0]       func,
  input  logic [SHW-1:0]   shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  localparam int NG = (WIDTH + 3) / 4;
  localparam int PW = NG * 4;

  localparam logic [2:0] F_SLL = 3'b000;
  localparam logic [2:0] F_ADD = 3'b001;
  localparam logic [2:0] F_SUB = 3'b010;
  localparam logic [2:0] F_OR  = 3'b011;
  localparam logic [2:0] F_AND = 3'b100;
  localparam logic [2:0] F_SRL = 3'b101;
  localparam logic [2:0] F_SRA = 3'b110;
  localparam logic [2:0] F_MUL = 3'b111;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;

  state_t state, state_n;

  logic             accept;
  logic             is_sub;
  logic [PW-1:0]    add_a, add_b, add_p, add_g, add_sum;
  logic [PW:0]      add_c;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
  logic [SHW-1:0]   cnt;
  logic             mul_last;

  assign accept    = in_valid && in_ready;
  assign in_ready  = !rst && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_MUL);
  assign fsm_state = state;

  // Subtraction is src1 + ~src2 + 1; the top group is zero-padded so c[WIDTH] is the true carry-out.
  assign is_sub = (func == F_SUB);
  assign add_a  = PW'(src1);
  assign add_b  = PW'(is_sub ? ~src2 : src2);
  assign add_p  = add_a ^ add_b;
  assign add_g  = add_a & add_b;

  always_comb begin
    logic [PW:0] c;
    c    = '0;
    c[0] = is_sub;
    for (int k = 0; k < NG; k++) begin
      c[4*k+1] = add_g[4*k] | (add_p[4*k] & c[4*k]);
      c[4*k+2] = add_g[4*k+1] | (add_p[4*k+1] & add_g[4*k])
               | (add_p[4*k+1] & add_p[4*k] & c[4*k]);
      c[4*k+3] = add_g[4*k+2] | (add_p[4*k+2] & add_g[4*k+1])
               | (add_p[4*k+2] & add_p[4*k+1] & add_g[4*k])
               | (add_p[4*k+2] & add_p[4*k+1] & add_p[4*k] & c[4*k]);
      c[4*k+4] = add_g[4*k+3] | (add_p[4*k+3] & add_g[4*k+2])
               | (add_p[4*k+3] & add_p[4*k+2] & add_g[4*k+1])
               | (add_p[4*k+3] & add_p[4*k+2] & add_p[4*k+1] & add_g[4*k])
               | (add_p[4*k+3] & add_p[4*k+2] & add_p[4*k+1] & add_p[4*k] & c[4*k]);
    end
    add_c = c;
  end

  assign add_sum = add_p ^ add_c[PW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (func)
      F_SLL: alu_res = src1 << shift;
      F_ADD, F_SUB: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_c[WIDTH];
        alu_v   = add_c[WIDTH] ^ add_c[WIDTH-1];
      end
      F_OR:    alu_res = src1 | src2;
      F_AND:   alu_res = src1 & src2;
      F_SRL:   alu_res = src1 >> shift;
      F_SRA:   alu_res = $unsigned($signed(src1) >>> shift);
      default: alu_res = '0;
    endcase
  end

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign mul_last = (cnt == SHW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) state_n = (func == F_MUL) ? S_MUL : S_DONE;
      S_MUL:  if (mul_last) state_n = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          if (accept) state_n = (func == F_MUL) ? S_MUL : S_DONE;
          else        state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Result registers only move on an accept or a multiply step, so they hold steady in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else if (accept) begin
      if (func == F_MUL) begin
        mcand  <= src1;
        mplier <= src2;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        result   <= alu_res;
        carry    <= alu_c;
        overflow <= alu_v;
      end
    end else if (state == S_MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (mul_last) begin
        result   <= acc_next;
        carry    <= 1'b0;
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: expected responses are queued at issue and
// checked by an independent monitor whenever a result handshake happens.
module tb_multicycle_alu;
  localparam int W   = 32;
  localparam int SHW = 5;

  localparam logic [2:0] F_SLL = 3'b000;
  localparam logic [2:0] F_ADD = 3'b001;
  localparam logic [2:0] F_SUB = 3'b010;
  localparam logic [2:0] F_OR  = 3'b011;
  localparam logic [2:0] F_AND = 3'b100;
  localparam logic [2:0] F_SRL = 3'b101;
  localparam logic [2:0] F_SRA = 3'b110;
  localparam logic [2:0] F_MUL = 3'b111;

  logic           clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]   src1, src2, result;
  logic [2:0]     func;
  logic [SHW-1:0] shift;
  logic           carry, overflow, busy;
  logic [1:0]     fsm_state;

  multicycle_alu #(.WIDTH(W), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .func(func), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .overflow(overflow), .busy(busy), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [W+1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [W+1:0] ex(input logic [W-1:0] r, input logic c, input logic v);
    return {r, c, v};
  endfunction

  // scoreboard monitor: a result transfer occurs on the next rising edge
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_response got=%h exp=none", {result, carry, overflow});
      end else begin
        check("response", 64'({result, carry, overflow}), 64'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks: all enter and leave at #1 after a rising edge
  task automatic send(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [SHW-1:0] sh, input logic [W+1:0] e, input bit push,
                      output int stalls);
    if (push) exp_q.push_back(e);
    func = f; src1 = a; src2 = b; shift = sh; in_valid = 1'b1;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      if (stalls > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout got=stalled exp=accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n, output int busy_cnt);
    n = 0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      n++;
      if (out_valid) break;
      if (busy && !in_ready) busy_cnt++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL wait_valid_timeout got=%0d exp=out_valid", n);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, n, bc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    src1 = '0; src2 = '0; func = '0; shift = '0;
    #2;
    check("reset_outputs", 64'({result, carry, overflow, out_valid, busy, in_ready, fsm_state}), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // ADD overflow case with latency measurement
    send(F_ADD, 32'h7FFF_FFFF, 32'h0000_0001, '0, ex(32'h8000_0000, 1'b0, 1'b1), 1'b1, st);
    wait_valid(n, bc);
    check("add_latency", 64'(n), 64'd1);

    // back-to-back directed vectors
    send(F_SUB, 32'h0000_0005, 32'h0000_0007, '0, ex(32'hFFFF_FFFE, 1'b0, 1'b0), 1'b1, st);
    send(F_SUB, 32'h0000_0007, 32'h0000_0005, '0, ex(32'h0000_0002, 1'b1, 1'b0), 1'b1, st);
    check("back_to_back_stalls", 64'(st), 64'd0);
    send(F_SUB, 32'h8000_0000, 32'h0000_0001, '0, ex(32'h7FFF_FFFF, 1'b1, 1'b1), 1'b1, st);
    send(F_ADD, 32'hFFFF_FFFF, 32'h0000_0001, '0, ex(32'h0000_0000, 1'b1, 1'b0), 1'b1, st);
    send(F_ADD, 32'h1234_5678, 32'h1111_1111, '0, ex(32'h2345_6789, 1'b0, 1'b0), 1'b1, st);
    send(F_SRA, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4,  ex(32'hF800_0000, 1'b0, 1'b0), 1'b1, st);
    send(F_SRA, 32'h7FFF_FFF0, 32'h0, 5'd4,  ex(32'h07FF_FFFF, 1'b0, 1'b0), 1'b1, st);
    send(F_SLL, 32'h0000_0001, 32'h0, 5'd31, ex(32'h8000_0000, 1'b0, 1'b0), 1'b1, st);
    send(F_SRL, 32'h8000_0000, 32'h0, 5'd0,  ex(32'h8000_0000, 1'b0, 1'b0), 1'b1, st);
    send(F_SRL, 32'h8000_0000, 32'h0, 5'd4,  ex(32'h0800_0000, 1'b0, 1'b0), 1'b1, st);
    send(F_OR,  32'hF0F0_F0F0, 32'h0F0F_0F0F, '0, ex(32'hFFFF_FFFF, 1'b0, 1'b0), 1'b1, st);
    send(F_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, '0, ex(32'h0F00_0F00, 1'b0, 1'b0), 1'b1, st);
    wait_valid(n, bc);

    // multiply latency and busy window
    send(F_MUL, 32'h0001_0001, 32'h0001_0001, '0, ex(32'h0002_0001, 1'b0, 1'b0), 1'b1, st);
    wait_valid(n, bc);
    check("mul_latency", 64'(n), 64'd33);
    check("mul_busy_cycles", 64'(bc), 64'd32);

    // a request held during MUL waits until DONE
    send(F_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, ex(32'h0000_0001, 1'b0, 1'b0), 1'b1, st);
    send(F_ADD, 32'h0000_0003, 32'h0000_0004, '0, ex(32'h0000_0007, 1'b0, 1'b0), 1'b1, st);
    check("stall_during_mul", 64'(st), 64'd32);
    send(F_MUL, 32'h0000_0003, 32'h0000_0005, '0, ex(32'h0000_000F, 1'b0, 1'b0), 1'b1, st);
    send(F_MUL, 32'h1234_5678, 32'h0000_0000, '0, ex(32'h0000_0000, 1'b0, 1'b0), 1'b1, st);
    wait_valid(n, bc);

    // reset in the middle of a multiply
    send(F_MUL, 32'h0000_00FF, 32'h0000_00FF, '0, '0, 1'b0, st);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_mul_reset_outputs", 64'({result, carry, overflow, out_valid, busy, in_ready, fsm_state}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("no_result_after_abort", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    send(F_ADD, 32'h0000_0100, 32'h0000_0023, '0, ex(32'h0000_0123, 1'b0, 1'b0), 1'b1, st);
    wait_valid(n, bc);
    check("add_after_reset_latency", 64'(n), 64'd1);

    // result hold under backpressure, then same-edge accept
    out_ready = 1'b0;
    send(F_OR, 32'h00FF_0000, 32'h0000_00AA, '0, ex(32'h00FF_00AA, 1'b0, 1'b0), 1'b1, st);
    wait_valid(n, bc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_stable", 64'({out_valid, result, carry, overflow}), {29'd0, 1'b1, 32'h00FF_00AA, 2'b00});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(F_AND, 32'hAAAA_5555, 32'hFFFF_0000, '0, ex(32'hAAAA_0000, 1'b0, 1'b0), 1'b1, st);
    check("accept_on_release", 64'(st), 64'd0);
    wait_valid(n, bc);

    repeat (5) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
